dma_ctrl: RTL and testbench

DMA controller that executes PIM transfer commands issued by the core's EX stage. Each command moves a block of 32-bit words between data memory and one or more PIM units. It latches the command, holds `busy_o` high so the core stalls, and drives the shared data-memory port with a req/gnt handshake. It sequences word reads and writes on the PIM side and reports completion by dropping `busy_o`.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_addr_gen.sv | 44 ++++
 rtl/dma_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dma_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the PIM DMA controller.
// Imported by dma_addr_gen and dma_ctrl.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    MEM_RD_DATA,
    PIM_RD,
    MEM_WR,
    DONE
  } dma_state_e;

  localparam logic [2:0] DMA_MEM2PIM = 3'b000;
  localparam logic [2:0] DMA_PIM2MEM = 3'b001;
  localparam logic [3:0] DMA_WORD_BE = 4'b1111;

endpackage

// File: rtl/dma_addr_gen.sv
// Memory address / PIM word index registers with load, step and last-word flag.
// Ports: load_i/base_i/nwords_i load, step_i advance, addr_o/idx_o/last_o.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [XLEN-1:0]  base_i,
  input  logic [IDX_W-1:0] nwords_i,
  input  logic             step_i,
  output logic [XLEN-1:0]  addr_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [XLEN-1:0]  addr_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] n_q;

  assign last_o = (idx_q == n_q - IDX_W'(1));
  assign addr_o = addr_q;
  assign idx_o  = idx_q;

  // Stepping stops on the last word so the index never exceeds N-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      idx_q  <= '0;
      n_q    <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      idx_q  <= '0;
      n_q    <= nwords_i;
    end else if (step_i && !last_o) begin
      addr_q <= addr_q + XLEN'(4);
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// PIM transfer DMA: moves N words between data memory and PIM units.
// Optional macro DMA_PERF_CNT_EN enables the saturating busy-cycle counter.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SIZE_W = 13,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_en_i,
  input  logic [2:0]        cmd_funct3_i,
  input  logic [3:0]        cmd_sel_pim_i,
  input  logic [SIZE_W-1:0] cmd_size_i,
  input  logic [XLEN-1:0]   cmd_mem_addr_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wr_data_o,
  input  logic [XLEN-1:0]   mem_rd_data_i,
  output logic [3:0]        mem_size_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [3:0]        pim_sel_o,
  output logic [SIZE_W-3:0] pim_addr_o,
  output logic              pim_wr_o,
  output logic              pim_rd_o,
  output logic [XLEN-1:0]   pim_wr_data_o,
  input  logic [XLEN-1:0]   pim_rd_data_i,
  output logic [PERF_W-1:0] perf_cycles_o
);

  localparam int IDX_W = SIZE_W - 2;

  dma_state_e state_q, state_d;

  logic             busy_q, err_q, wr_first_q;
  logic [3:0]       sel_q;
  logic [XLEN-1:0]  wdata_q;
  logic [IDX_W-1:0] cmd_n;
  logic             cmd_legal, accept, load, step, last;
  logic             unused_bits;

  assign cmd_n     = cmd_size_i[SIZE_W-1:2];
  assign cmd_legal = (cmd_funct3_i == DMA_MEM2PIM ||
                      cmd_funct3_i == DMA_PIM2MEM) &&
                     (cmd_sel_pim_i != 4'b0000);
  assign accept    = (state_q == IDLE) && cmd_en_i;
  assign load      = accept && cmd_legal && (cmd_n != '0);

  assign unused_bits = ^{cmd_size_i[1:0], cmd_mem_addr_i[1:0]};

  dma_addr_gen #(
    .XLEN (XLEN),
    .IDX_W(IDX_W)
  ) u_addr_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .base_i  ({cmd_mem_addr_i[XLEN-1:2], 2'b00}),
    .nwords_i(cmd_n),
    .step_i  (step),
    .addr_o  (mem_addr_o),
    .idx_o   (pim_addr_o),
    .last_o  (last)
  );

  always_comb begin
    state_d       = state_q;
    step          = 1'b0;
    mem_req_o     = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_size_o    = 4'b0000;
    pim_wr_o      = 1'b0;
    pim_rd_o      = 1'b0;
    pim_wr_data_o = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_en_i) begin
          if (!cmd_legal || cmd_n == '0)
            state_d = DONE;
          else if (cmd_funct3_i == DMA_MEM2PIM)
            state_d = MEM_RD;
          else
            state_d = PIM_RD;
        end
      end
      MEM_RD: begin
        mem_req_o  = 1'b1;
        mem_read_o = 1'b1;
        mem_size_o = DMA_WORD_BE;
        if (mem_gnt_i) state_d = MEM_RD_DATA;
      end
      MEM_RD_DATA: begin
        pim_wr_o      = 1'b1;
        pim_wr_data_o = mem_rd_data_i;
        step          = 1'b1;
        state_d       = last ? DONE : MEM_RD;
      end
      PIM_RD: begin
        pim_rd_o = 1'b1;
        state_d  = MEM_WR;
      end
      MEM_WR: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_size_o  = DMA_WORD_BE;
        if (mem_gnt_i) begin
          step    = 1'b1;
          state_d = last ? DONE : PIM_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PIM read data arrives in the first MEM_WR cycle; pass it straight
  // through then, and from the capture register while waiting for grant.
  assign mem_wr_data_o = wr_first_q ? pim_rd_data_i : wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= 4'b0000;
      wr_first_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      err_q      <= accept && !cmd_legal;
      wr_first_q <= (state_q == PIM_RD);
      if (accept)     sel_q   <= cmd_sel_pim_i;
      if (wr_first_q) wdata_q <= pim_rd_data_i;
    end
  end

  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign pim_sel_o = sel_q;

`ifdef DMA_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      perf_q <= '0;
    else if (busy_q && perf_q != '1)
      perf_q <= perf_q + PERF_W'(1);
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed self-checking bench for dma_ctrl.
// Memory and PIM responders are modelled inline in run_cmd.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_en;
  logic [2:0]  cmd_f3;
  logic [3:0]  cmd_sel;
  logic [12:0] cmd_size;
  logic [31:0] cmd_addr;
  logic        busy_o, err_o, mem_req_o, mem_gnt;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data;
  logic [3:0]  mem_size_o, pim_sel_o;
  logic        mem_read_o, mem_write_o, pim_wr_o, pim_rd_o;
  logic [10:0] pim_addr_o;
  logic [31:0] pim_wr_data_o, pim_rd_data, perf_o;

  int tests = 0;
  int fails = 0;

  int busy_cnt, err_cnt, err_nobusy, req_n;
  int rd_n, wr_n, pw_n, pr_n, stable_bad;
  logic [31:0] rd_addr [8];
  logic [31:0] wr_addr [8];
  logic [31:0] wr_dat  [8];
  logic [31:0] pw_dat  [8];
  logic [10:0] pw_idx  [8];
  logic [10:0] pr_idx  [8];

  always #5 clk = ~clk;

  dma_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_en_i      (cmd_en),
    .cmd_funct3_i  (cmd_f3),
    .cmd_sel_pim_i (cmd_sel),
    .cmd_size_i    (cmd_size),
    .cmd_mem_addr_i(cmd_addr),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_data_i (mem_rd_data),
    .mem_size_o    (mem_size_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .pim_sel_o     (pim_sel_o),
    .pim_addr_o    (pim_addr_o),
    .pim_wr_o      (pim_wr_o),
    .pim_rd_o      (pim_rd_o),
    .pim_wr_data_o (pim_wr_data_o),
    .pim_rd_data_i (pim_rd_data),
    .perf_cycles_o (perf_o)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pimw(input logic [10:0] i);
    return 32'hC0DE_0000 + {21'd0, i};
  endfunction

  // Issues one command and plays memory/PIM until busy falls.
  task automatic run_cmd(input logic [2:0] f3, input logic [3:0] sel,
                         input logic [12:0] size, input logic [31:0] addr,
                         input int dly, input int abort_at, input bit poke);
    int  wcnt = 0;
    bit  started = 0, done = 0, waiting = 0;
    logic [31:0] hold_a, hold_d;
    busy_cnt = 0; err_cnt = 0; err_nobusy = 0; req_n = 0;
    rd_n = 0; wr_n = 0; pw_n = 0; pr_n = 0; stable_bad = 0;
    hold_a = '0; hold_d = '0;
    @(negedge clk);
    cmd_en = 1'b1; cmd_f3 = f3; cmd_sel = sel;
    cmd_size = size; cmd_addr = addr;
    mem_gnt = (dly == 0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cmd_en = 1'b0;
      if (poke && c == 3) begin
        cmd_en = 1'b1; cmd_f3 = 3'b101;
      end
      if (err_o) err_cnt++;
      if (err_o && !busy_o) err_nobusy++;
      if (!busy_o && started) begin
        done = 1; break;
      end
      if (busy_o) begin
        started = 1; busy_cnt++;
      end
      if (pim_wr_o && pw_n < 8) begin
        pw_idx[pw_n] = pim_addr_o; pw_dat[pw_n] = pim_wr_data_o; pw_n++;
      end
      if (pim_rd_o && pr_n < 8) begin
        pr_idx[pr_n] = pim_addr_o; pim_rd_data = pimw(pim_addr_o); pr_n++;
      end
      if (mem_req_o) begin
        req_n++;
        if (!waiting) begin
          hold_a = mem_addr_o; hold_d = mem_wr_data_o; waiting = 1;
        end else if (mem_addr_o !== hold_a ||
                     (mem_write_o && mem_wr_data_o !== hold_d)) begin
          stable_bad++;
        end
        if (wcnt == dly) begin
          mem_gnt = 1'b1; wcnt = 0; waiting = 0;
          if (mem_read_o && rd_n < 8) begin
            rd_addr[rd_n] = mem_addr_o; mem_rd_data = memw(mem_addr_o); rd_n++;
          end
          if (mem_write_o && wr_n < 8) begin
            wr_addr[wr_n] = mem_addr_o; wr_dat[wr_n] = mem_wr_data_o; wr_n++;
          end
        end else begin
          mem_gnt = 1'b0; wcnt++;
        end
      end else begin
        mem_gnt = (dly == 0);
      end
      if (abort_at > 0 && pw_n == abort_at) begin
        rst_n = 1'b0; done = 1; break;
      end
    end
    mem_gnt = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL cmd_timeout: busy never completed (busy_cnt=%0d)", busy_cnt);
    end
  endtask

  task automatic test_reset;
    logic [159:0] outs;
    rst_n = 1'b0; cmd_en = 0; cmd_f3 = 0; cmd_sel = 0; cmd_size = 0;
    cmd_addr = 0; mem_gnt = 0; mem_rd_data = 0; pim_rd_data = 0;
    repeat (3) @(negedge clk);
    outs = {busy_o, err_o, mem_req_o, mem_read_o, mem_write_o, pim_wr_o,
            pim_rd_o, mem_size_o, pim_sel_o, pim_addr_o, mem_addr_o,
            mem_wr_data_o, pim_wr_data_o, perf_o};
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [31:0] exp_perf;
`ifdef DMA_PERF_CNT_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    run_cmd(3'b000, 4'b0001, 13'd8, 32'hFFFF_FFFC, 0, 0, 0);
    tests++;
    if (rd_n !== 2 || rd_addr[0] !== 32'hFFFF_FFFC || rd_addr[1] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_addr: got n=%0d %h %h want 2 fffffffc 00000000",
               rd_n, rd_addr[0], rd_addr[1]);
    end
    tests++;
    if (busy_cnt !== 5) begin
      fails++; $display("FAIL wrap_busy: got %0d want 5", busy_cnt);
    end
    tests++;
    if (perf_o !== exp_perf) begin
      fails++; $display("FAIL perf_cycles: got %0d want %0d", perf_o, exp_perf);
    end
  endtask

  task automatic test_mem2pim;
    run_cmd(3'b000, 4'b0001, 13'd16, 32'h2000_0000, 0, 0, 1);
    tests++;
    if (busy_cnt !== 9) begin
      fails++; $display("FAIL m2p_busy: got %0d want 9", busy_cnt);
    end
    tests++;
    if (pw_n !== 4 || rd_n !== 4) begin
      fails++; $display("FAIL m2p_count: got wr=%0d rd=%0d want 4 4", pw_n, rd_n);
    end
    for (int i = 0; i < 4 && i < pw_n && i < rd_n; i++) begin
      tests++;
      if (pw_idx[i] !== 11'(i) || rd_addr[i] !== 32'h2000_0000 + 32'(4 * i) ||
          pw_dat[i] !== memw(32'h2000_0000 + 32'(4 * i))) begin
        fails++;
        $display("FAIL m2p_word%0d: got idx=%0d addr=%h data=%h want idx=%0d addr=%h data=%h",
                 i, pw_idx[i], rd_addr[i], pw_dat[i], i,
                 32'h2000_0000 + 32'(4 * i), memw(32'h2000_0000 + 32'(4 * i)));
      end
    end
    tests++;
    if (err_cnt !== 0 || pim_sel_o !== 4'b0001) begin
      fails++;
      $display("FAIL m2p_busy_cmd: got err=%0d sel=%b want 0 0001", err_cnt, pim_sel_o);
    end
  endtask

  task automatic test_pim2mem;
    run_cmd(3'b001, 4'b0110, 13'd8, 32'h2000_0103, 2, 0, 0);
    tests++;
    if (busy_cnt !== 9) begin
      fails++; $display("FAIL p2m_busy: got %0d want 9", busy_cnt);
    end
    tests++;
    if (wr_n !== 2 || wr_addr[0] !== 32'h2000_0100 || wr_addr[1] !== 32'h2000_0104) begin
      fails++;
      $display("FAIL p2m_addr: got n=%0d %h %h want 2 20000100 20000104",
               wr_n, wr_addr[0], wr_addr[1]);
    end
    tests++;
    if (wr_dat[0] !== pimw(11'd0) || wr_dat[1] !== pimw(11'd1)) begin
      fails++;
      $display("FAIL p2m_data: got %h %h want %h %h",
               wr_dat[0], wr_dat[1], pimw(11'd0), pimw(11'd1));
    end
    tests++;
    if (pr_n !== 2 || pr_idx[0] !== 11'd0 || pr_idx[1] !== 11'd1) begin
      fails++;
      $display("FAIL p2m_pim_rd: got n=%0d %0d %0d want 2 0 1", pr_n, pr_idx[0], pr_idx[1]);
    end
    tests++;
    if (stable_bad !== 0 || req_n !== 6) begin
      fails++;
      $display("FAIL p2m_req_hold: got unstable=%0d req_cycles=%0d want 0 6",
               stable_bad, req_n);
    end
  endtask

  task automatic test_illegal;
    run_cmd(3'b101, 4'b0001, 13'd16, 32'h2000_0000, 0, 0, 0);
    tests++;
    if (busy_cnt !== 1 || err_cnt !== 1 || err_nobusy !== 0) begin
      fails++;
      $display("FAIL illegal_f3: got busy=%0d err=%0d err_late=%0d want 1 1 0",
               busy_cnt, err_cnt, err_nobusy);
    end
    tests++;
    if (req_n + pw_n + pr_n !== 0) begin
      fails++; $display("FAIL illegal_f3_strobes: got %0d want 0", req_n + pw_n + pr_n);
    end
    run_cmd(3'b000, 4'b0000, 13'd16, 32'h2000_0000, 0, 0, 0);
    tests++;
    if (busy_cnt !== 1 || err_cnt !== 1 || err_nobusy !== 0 || req_n + pw_n + pr_n !== 0) begin
      fails++;
      $display("FAIL illegal_sel: got busy=%0d err=%0d err_late=%0d strobes=%0d want 1 1 0 0",
               busy_cnt, err_cnt, err_nobusy, req_n + pw_n + pr_n);
    end
  endtask

  task automatic test_zero_len;
    run_cmd(3'b000, 4'b0001, 13'd3, 32'h2000_0000, 0, 0, 0);
    tests++;
    if (busy_cnt !== 1 || err_cnt !== 0 || req_n + pw_n + pr_n !== 0) begin
      fails++;
      $display("FAIL zero_len: got busy=%0d err=%0d strobes=%0d want 1 0 0",
               busy_cnt, err_cnt, req_n + pw_n + pr_n);
    end
  endtask

  task automatic test_reset_mid;
    logic [95:0] outs;
    run_cmd(3'b000, 4'b1000, 13'd16, 32'h2000_0000, 0, 2, 0);
    #1;
    outs = {busy_o, err_o, mem_req_o, mem_read_o, mem_write_o, pim_wr_o,
            pim_rd_o, mem_size_o, pim_sel_o, pim_addr_o, mem_addr_o, pim_wr_data_o};
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_mid_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(3'b000, 4'b0001, 13'd16, 32'h2000_0000, 0, 0, 0);
    tests++;
    if (pw_n !== 4 || pw_idx[0] !== 11'd0 || busy_cnt !== 9) begin
      fails++;
      $display("FAIL reset_mid_restart: got n=%0d idx0=%0d busy=%0d want 4 0 9",
               pw_n, pw_idx[0], busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_mem2pim();
    test_pim2mem();
    test_illegal();
    test_zero_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
